// File: rtl/reg_bank8_rr.sv
// 8-entry register bank with valid/ready request/response and an 8-cycle clear sequencer.
// Optional feature: define REG_BANK8_RR_WRITE_ACK_EN to return a response for accepted writes.
module reg_bank8_rr #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   CLR_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [2:0]       req_addr_i,
    input  logic [WIDTH-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    input  logic             clr_i,
    output logic             busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [8];
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] rsp_next;
    logic             accept;
    logic             wr_accept;
    logic             rsp_load;

    // rst_n_i is folded in so the request side reads as not-ready while reset is held
    assign req_ready_o = rst_n_i && (state_q == IDLE) && !clr_i && (!rsp_valid_o || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign wr_accept   = accept && req_we_i;
    assign sel_word    = mem[req_addr_i];
    assign busy_o      = (state_q == CLEAR);

`ifdef REG_BANK8_RR_WRITE_ACK_EN
    assign rsp_load = accept;
    assign rsp_next = req_we_i ? req_wdata_i : sel_word;
`else
    assign rsp_load = accept && !req_we_i;
    assign rsp_next = sel_word;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = 3'd0;
                end
            end
            CLEAR: begin
                // counter wraps 7 -> 0 on the same edge that leaves CLEAR
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // writes from the request port and the sequencer never coincide: req_ready_o is low in CLEAR
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= CLR_VALUE;
            end
        end else if (state_q == CLEAR) begin
            mem[cnt_q] <= CLR_VALUE;
        end else if (wr_accept) begin
            mem[req_addr_i] <= req_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else if (rsp_load) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= rsp_next;
        end else if (rsp_valid_o && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule
